// File: rtl/somador_paridade.sv
// somador_paridade: six-operand 4-bit adder with parity flag.
// Two-stage pipeline: pair sums, then total sum and parity.
module somador_paridade (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] m0,
  input  logic [3:0] m1,
  input  logic [3:0] m2,
  input  logic [3:0] m3,
  input  logic [3:0] m4,
  input  logic [3:0] m5,
  output logic [6:0] soma,
  output logic       p_ou_i,
  output logic       out_valid
);

  logic [4:0] s01;
  logic [4:0] s23;
  logic [4:0] s45;
  logic       v1;
  logic [6:0] total;

  assign total = {2'b00, s01}
               + {2'b00, s23}
               + {2'b00, s45};

  // stage 1: pair sums, captured only on qualified cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      s01 <= '0;
      s23 <= '0;
      s45 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        s01 <= {1'b0, m0} + {1'b0, m1};
        s23 <= {1'b0, m2} + {1'b0, m3};
        s45 <= {1'b0, m4} + {1'b0, m5};
      end
    end
  end

  // stage 2: full sum, parity from the full sum, valid strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      soma      <= '0;
      p_ou_i    <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        soma   <= total;
        p_ou_i <= total[0];
      end
    end
  end

endmodule

// File: tb/tb_somador_paridade.sv
// tb_somador_paridade: random and directed checks against
// a history-based model of accepted operand sets.
module tb_somador_paridade;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] m [6];
  logic [6:0] soma;
  logic       p_ou_i;
  logic       out_valid;

  int total = 0;
  int bad = 0;
  int edge_n = 0;
  int acc_edge[$];
  int acc_sum[$];

  always #5 clk = ~clk;

  somador_paridade dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .m0(m[0]),
    .m1(m[1]),
    .m2(m[2]),
    .m3(m[3]),
    .m4(m[4]),
    .m5(m[5]),
    .soma(soma),
    .p_ou_i(p_ou_i),
    .out_valid(out_valid)
  );

  function automatic int op_sum();
    int r = 0;
    for (int i = 0; i < 6; i++) r += int'(m[i]);
    return r;
  endfunction

  // result visible one edge after the accepting edge
  function automatic bit exp_v();
    foreach (acc_edge[i])
      if (acc_edge[i] == edge_n - 1) return 1'b1;
    return 1'b0;
  endfunction

  // latest set accepted at least one edge ago, else 0
  function automatic int exp_s();
    int r = 0;
    foreach (acc_edge[i])
      if (acc_edge[i] <= edge_n - 1) r = acc_sum[i];
    return r;
  endfunction

  task automatic set_ops(input int a0, input int a1,
                         input int a2, input int a3,
                         input int a4, input int a5);
    m[0] = 4'(a0); m[1] = 4'(a1); m[2] = 4'(a2);
    m[3] = 4'(a3); m[4] = 4'(a4); m[5] = 4'(a5);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 6; i++) m[i] = 4'($urandom_range(0, 15));
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    if (rst_n && in_valid) begin
      acc_edge.push_back(edge_n);
      acc_sum.push_back(op_sum());
    end
    #1;
  endtask

  task automatic chk_model(input string nm);
    int s = exp_s();
    bit v = exp_v();
    total++;
    if (out_valid !== v) begin
      bad++;
      $display("FAIL %s out_valid got=%0b want=%0b", nm, out_valid, v);
    end
    total++;
    if (soma !== 7'(s)) begin
      bad++;
      $display("FAIL %s soma got=%0d want=%0d", nm, soma, s);
    end
    total++;
    if (p_ou_i !== 1'(s % 2)) begin
      bad++;
      $display("FAIL %s p_ou_i got=%0b want=%0b", nm, p_ou_i, s % 2);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    acc_edge.delete();
    acc_sum.delete();
    #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      tick();
    end
    rand_ops();
    do_reset();
    total++;
    if (soma !== 7'd0 || p_ou_i !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_async soma=%0d p=%0b v=%0b want 0/0/0",
               soma, p_ou_i, out_valid);
    end
    tick();
    tick();
    chk_model("reset_held");
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk_model("reset_release");
  endtask

  task automatic test_nominal();
    set_ops(1, 10, 4, 0, 9, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk_model("nominal");
    total++;
    if (out_valid !== 1'b1 || soma !== 7'd25 || p_ou_i !== 1'b1) begin
      bad++;
      $display("FAIL nominal_const v=%0b soma=%0d p=%0b want 1/25/1",
               out_valid, soma, p_ou_i);
    end
  endtask

  task automatic test_extremes();
    int v [3][6] = '{'{0, 0, 0, 0, 0, 0},
                     '{15, 15, 15, 15, 15, 15},
                     '{1, 0, 0, 0, 0, 0}};
    int ws [3] = '{0, 90, 1};
    for (int k = 0; k < 3; k++) begin
      set_ops(v[k][0], v[k][1], v[k][2], v[k][3], v[k][4], v[k][5]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk_model("extreme");
      total++;
      if (out_valid !== 1'b1 || soma !== 7'(ws[k])
          || p_ou_i !== 1'(ws[k] % 2)) begin
        bad++;
        $display("FAIL extreme_%0d v=%0b soma=%0d p=%0b want 1/%0d/%0d",
                 k, out_valid, soma, p_ou_i, ws[k], ws[k] % 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ws [3] = '{25, 90, 0};
    in_valid = 1'b1;
    set_ops(1, 10, 4, 0, 9, 1);
    tick();
    set_ops(15, 15, 15, 15, 15, 15);
    tick();
    chk_model("b2b_0");
    total++;
    if (out_valid !== 1'b1 || soma !== 7'(ws[0]) || p_ou_i !== 1'b1) begin
      bad++;
      $display("FAIL b2b_0 v=%0b soma=%0d p=%0b want 1/25/1",
               out_valid, soma, p_ou_i);
    end
    set_ops(0, 0, 0, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    chk_model("b2b_1");
    total++;
    if (out_valid !== 1'b1 || soma !== 7'(ws[1]) || p_ou_i !== 1'b0) begin
      bad++;
      $display("FAIL b2b_1 v=%0b soma=%0d p=%0b want 1/90/0",
               out_valid, soma, p_ou_i);
    end
    tick();
    chk_model("b2b_2");
    total++;
    if (out_valid !== 1'b1 || soma !== 7'(ws[2]) || p_ou_i !== 1'b0) begin
      bad++;
      $display("FAIL b2b_2 v=%0b soma=%0d p=%0b want 1/0/0",
               out_valid, soma, p_ou_i);
    end
  endtask

  task automatic test_hold();
    logic [6:0] s0;
    logic p0;
    set_ops(1, 10, 4, 0, 9, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    s0 = soma;
    p0 = p_ou_i;
    for (int k = 0; k < 3; k++) begin
      set_ops(15, 14, 13, 12, 11, 10);
      tick();
      chk_model("hold");
      total++;
      if (out_valid !== 1'b0 || soma !== 7'd25 || p_ou_i !== 1'b1) begin
        bad++;
        $display("FAIL hold v=%0b soma=%0d p=%0b want 0/%0d/%0b",
                 out_valid, soma, p_ou_i, s0, p0);
      end
    end
  endtask

  task automatic test_midflight();
    set_ops(1, 10, 4, 0, 9, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    do_reset();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_model("midflight");
      total++;
      if (out_valid !== 1'b0 || soma !== 7'd0) begin
        bad++;
        $display("FAIL midflight v=%0b soma=%0d want 0/0",
                 out_valid, soma);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      rand_ops();
      in_valid = 1'($urandom_range(0, 1));
      tick();
      chk_model("random");
    end
    in_valid = 1'b0;
    tick();
    chk_model("random_tail");
  endtask

  initial begin
    set_ops(0, 0, 0, 0, 0, 0);
    test_reset();
    test_nominal();
    test_extremes();
    test_back_to_back();
    test_hold();
    test_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
